game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_game_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_ctrl
// Description : Tic-tac-toe game sequencer. Alternates player (X) and AI (O)
//               turns, validates move requests against the board contents,
//               drives the external board through a submit/update_loc
//               handshake (board acts on the falling edge of submit), applies
//               an AI timeout fallback and detects win/draw.
// Ports       : clk, reset_n (sync, active-low), new_game
//               player_valid/player_loc -> player_ready
//               ai_start, ai_valid/ai_loc -> ai_ready
//               board_state (18b, cell i at [2i+1:2i])
//               update_loc, submit, board_reset -> board
//               reject, winner, game_over, move_count
// Revision    : 1.0 - initial release
// ============================================================================
module game_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_game,
    input  logic        player_valid,
    input  logic [3:0]  player_loc,
    output logic        player_ready,
    output logic        ai_start,
    input  logic        ai_valid,
    input  logic [3:0]  ai_loc,
    output logic        ai_ready,
    input  logic [17:0] board_state,
    output logic [3:0]  update_loc,
    output logic        submit,
    output logic        board_reset,
    output logic        reject,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [3:0]  move_count
);

    localparam logic [1:0] c_blank   = 2'b00;
    localparam logic [1:0] c_x       = 2'b01;
    localparam logic [1:0] c_o       = 2'b10;
    localparam logic [1:0] c_draw    = 2'b11;
    localparam logic       c_mover_x = 1'b0;
    localparam logic       c_mover_o = 1'b1;
    localparam logic [7:0] c_timeout = 8'd255;
    localparam logic [3:0] c_cells   = 4'd9;

    typedef enum logic [3:0] {
        S_CLEAR   = 4'd0,
        S_CLR_END = 4'd1,
        S_PLAYER  = 4'd2,
        S_AI_REQ  = 4'd3,
        S_AI_WAIT = 4'd4,
        S_COMMIT  = 4'd5,
        S_SETTLE  = 4'd6,
        S_CHECK   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] loc_q, loc_d;
    logic [3:0] move_count_q, move_count_d;
    logic [1:0] winner_q, winner_d;
    logic       mover_q, mover_d;
    logic [7:0] timer_q, timer_d;
    logic       submit_prev_q, submit_prev_d;

    logic       submit_raw;
    logic       board_reset_raw;
    logic [3:0] lowest_blank;
    logic [1:0] winner_calc;

    // Board padded to 16 cells; the phantom cells 9..15 read as occupied so
    // any out-of-range index can never look blank.
    logic [15:0][1:0] cells;
    assign cells = {{7{2'b11}}, board_state};

    function automatic logic is_legal(input logic [3:0] loc, input logic [15:0][1:0] b);
        return (loc < c_cells) && (b[loc] == c_blank);
    endfunction

    function automatic logic has_line(input logic [15:0][1:0] b, input logic [1:0] p);
        return ((b[0] == p) && (b[1] == p) && (b[2] == p)) ||
               ((b[3] == p) && (b[4] == p) && (b[5] == p)) ||
               ((b[6] == p) && (b[7] == p) && (b[8] == p)) ||
               ((b[0] == p) && (b[3] == p) && (b[6] == p)) ||
               ((b[1] == p) && (b[4] == p) && (b[7] == p)) ||
               ((b[2] == p) && (b[5] == p) && (b[8] == p)) ||
               ((b[0] == p) && (b[4] == p) && (b[8] == p)) ||
               ((b[2] == p) && (b[4] == p) && (b[6] == p));
    endfunction

    // Scan downward so the last hit is the lowest-index blank cell.
    always_comb begin
        lowest_blank = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (cells[i] == c_blank) begin
                lowest_blank = 4'(i);
            end
        end
    end

    // A completed line outranks a full board.
    always_comb begin
        winner_calc = c_blank;
        if (has_line(cells, c_x)) begin
            winner_calc = c_x;
        end else if (has_line(cells, c_o)) begin
            winner_calc = c_o;
        end else if (move_count_q == c_cells) begin
            winner_calc = c_draw;
        end
    end

    always_comb begin
        state_d         = state_q;
        loc_d           = loc_q;
        move_count_d    = move_count_q;
        winner_d        = winner_q;
        mover_d         = mover_q;
        timer_d         = timer_q;
        submit_raw      = 1'b0;
        board_reset_raw = 1'b0;
        player_ready    = 1'b0;
        ai_ready        = 1'b0;
        ai_start        = 1'b0;
        reject          = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // If submit was high last cycle (abort from S_COMMIT or a held
                // new_game) it must drop now; that falling edge, with
                // board_reset high, is what clears the board.
                submit_raw      = ~submit_prev_q;
                board_reset_raw = 1'b1;
                move_count_d    = 4'd0;
                winner_d        = c_blank;
                mover_d         = c_mover_x;
                state_d         = S_CLR_END;
            end
            S_CLR_END: begin
                board_reset_raw = 1'b1;
                state_d         = S_PLAYER;
            end
            S_PLAYER: begin
                player_ready = 1'b1;
                if (player_valid) begin
                    if (is_legal(player_loc, cells)) begin
                        loc_d   = player_loc;
                        state_d = S_COMMIT;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_AI_REQ: begin
                ai_start = 1'b1;
                timer_d  = 8'd0;
                state_d  = S_AI_WAIT;
            end
            S_AI_WAIT: begin
                ai_ready = 1'b1;
                if (ai_valid && is_legal(ai_loc, cells)) begin
                    loc_d   = ai_loc;
                    state_d = S_COMMIT;
                end else begin
                    reject = ai_valid;
                    if (timer_q == c_timeout) begin
                        loc_d   = lowest_blank;
                        state_d = S_COMMIT;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            S_COMMIT: begin
                submit_raw = 1'b1;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                move_count_d = move_count_q + 4'd1;
                mover_d      = ~mover_q;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                winner_d = winner_calc;
                if (winner_calc != c_blank) begin
                    state_d = S_DONE;
                end else if (mover_q == c_mover_o) begin
                    state_d = S_AI_REQ;
                end else begin
                    state_d = S_PLAYER;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        if (new_game) begin
            state_d = S_CLEAR;
        end
    end

    // The register holds S_CLEAR while reset_n is low; masking the board
    // strobes keeps the board quiet until reset is released, after which the
    // S_CLEAR/S_CLR_END pair runs and clears it.
    assign submit        = reset_n & submit_raw;
    assign board_reset   = reset_n & board_reset_raw;
    assign submit_prev_d = submit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_CLEAR;
            loc_q         <= 4'd0;
            move_count_q  <= 4'd0;
            winner_q      <= c_blank;
            mover_q       <= c_mover_x;
            timer_q       <= 8'd0;
            submit_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            loc_q         <= loc_d;
            move_count_q  <= move_count_d;
            winner_q      <= winner_d;
            mover_q       <= mover_d;
            timer_q       <= timer_d;
            submit_prev_q <= submit_prev_d;
        end
    end

    assign update_loc = loc_q;
    assign winner     = winner_q;
    assign move_count = move_count_q;
    assign game_over  = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_ctrl
// Description : Self-checking bench for game_ctrl. Includes a behavioural
//               board that commits on the falling edge of submit, a
//               cycle-by-cycle vector table for a scripted game, and directed
//               sequences for win, draw, AI timeout and new_game aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_game = 1'b0;
    logic        player_valid = 1'b0;
    logic [3:0]  player_loc = 4'd0;
    logic        player_ready;
    logic        ai_start;
    logic        ai_valid = 1'b0;
    logic [3:0]  ai_loc = 4'd0;
    logic        ai_ready;
    logic [17:0] board = 18'd0;
    logic [3:0]  update_loc;
    logic        submit;
    logic        board_reset;
    logic        reject;
    logic [1:0]  winner;
    logic        game_over;
    logic [3:0]  move_count;

    int total = 0;
    int bad   = 0;

    game_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .new_game     (new_game),
        .player_valid (player_valid),
        .player_loc   (player_loc),
        .player_ready (player_ready),
        .ai_start     (ai_start),
        .ai_valid     (ai_valid),
        .ai_loc       (ai_loc),
        .ai_ready     (ai_ready),
        .board_state  (board),
        .update_loc   (update_loc),
        .submit       (submit),
        .board_reset  (board_reset),
        .reject       (reject),
        .winner       (winner),
        .game_over    (game_over),
        .move_count   (move_count)
    );

    always #5 clk = ~clk;

    // Board model: acts on a falling edge of submit; pieces alternate X, O.
    logic       sub_prev = 1'b0;
    logic [1:0] piece    = 2'b01;
    always @(posedge clk) begin
        if (sub_prev === 1'b1 && submit === 1'b1) begin
            total++;
            bad++;
            $display("FAIL submit_back_to_back: got two consecutive high cycles, want at most one");
        end
        if (sub_prev === 1'b1 && submit === 1'b0) begin
            if (board_reset) begin
                board <= 18'd0;
                piece <= 2'b01;
            end else if (update_loc < 4'd9) begin
                board[2*update_loc +: 2] <= piece;
                piece <= (piece == 2'b01) ? 2'b10 : 2'b01;
            end
        end
        sub_prev <= submit;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return player_ready;
            1:       return ai_ready;
            default: return game_over;
        endcase
    endfunction

    // Bounded wait for a DUT status signal; entered and left at negedge+1.
    task automatic wait_sig(input int which, input string nm);
        int n = 0;
        while (sel(which) !== 1'b1 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk(nm, 32'(sel(which)), 32'd1);
    endtask

    task automatic play_player(input logic [3:0] loc);
        wait_sig(0, "wait_player_ready");
        player_valid = 1'b1;
        player_loc   = loc;
        #1;
        chk("player_no_reject", 32'(reject), 32'd0);
        @(negedge clk); #1;
        player_valid = 1'b0;
        chk("player_commit_submit", 32'(submit), 32'd1);
        chk("player_commit_loc", 32'(update_loc), 32'(loc));
    endtask

    task automatic play_ai(input logic [3:0] loc);
        wait_sig(1, "wait_ai_ready");
        ai_valid = 1'b1;
        ai_loc   = loc;
        @(negedge clk); #1;
        ai_valid = 1'b0;
        chk("ai_commit_submit", 32'(submit), 32'd1);
        chk("ai_commit_loc", 32'(update_loc), 32'(loc));
    endtask

    typedef struct {
        logic       rst_n;
        logic       ng;
        logic       pv;
        logic [3:0] pl;
        logic       av;
        logic [3:0] al;
        logic [6:0] flags;  // {submit, board_reset, player_ready, ai_ready, ai_start, reject, game_over}
        logic [1:0] win;
        logic [3:0] upd;
        logic [3:0] mc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic ng, input logic pv, input logic [3:0] pl,
                       input logic av, input logic [3:0] al, input logic [6:0] flags,
                       input logic [1:0] win, input logic [3:0] upd, input logic [3:0] mc);
        vecs.push_back('{r, ng, pv, pl, av, al, flags, win, upd, mc});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] act_v, exp_v;
        int n;

        //   rst ng pv pl    av al    flags        win    upd   mc
        add(0, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd0, 4'd0);  // held in reset
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1100000, 2'b00, 4'd0, 4'd0);  // S_CLEAR
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0100000, 2'b00, 4'd0, 4'd0);  // S_CLR_END
        add(1, 0, 1, 4'd4, 0, 4'd0, 7'b0010000, 2'b00, 4'd0, 4'd0);  // X -> 4
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1000000, 2'b00, 4'd4, 4'd0);  // commit
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd4, 4'd0);  // settle
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd4, 4'd1);  // check
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000100, 2'b00, 4'd4, 4'd1);  // ai_start
        add(1, 0, 1, 4'd0, 0, 4'd0, 7'b0001000, 2'b00, 4'd4, 4'd1);  // player ignored
        add(1, 0, 0, 4'd0, 1, 4'd4, 7'b0001010, 2'b00, 4'd4, 4'd1);  // AI occupied -> reject
        add(1, 0, 0, 4'd0, 1, 4'd3, 7'b0001000, 2'b00, 4'd4, 4'd1);  // O -> 3
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1000000, 2'b00, 4'd3, 4'd1);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd3, 4'd1);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd3, 4'd2);
        add(1, 0, 1, 4'd4, 0, 4'd0, 7'b0010010, 2'b00, 4'd3, 4'd2);  // occupied -> reject
        add(1, 0, 1, 4'd12,0, 4'd0, 7'b0010010, 2'b00, 4'd3, 4'd2);  // out of range -> reject
        add(1, 0, 1, 4'd0, 0, 4'd0, 7'b0010000, 2'b00, 4'd3, 4'd2);  // X -> 0
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1000000, 2'b00, 4'd0, 4'd2);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd0, 4'd2);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd0, 4'd3);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000100, 2'b00, 4'd0, 4'd3);
        add(1, 0, 0, 4'd0, 1, 4'd1, 7'b0001000, 2'b00, 4'd0, 4'd3);  // O -> 1
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1000000, 2'b00, 4'd1, 4'd3);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd1, 4'd3);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd1, 4'd4);
        add(1, 0, 1, 4'd8, 0, 4'd0, 7'b0010000, 2'b00, 4'd1, 4'd4);  // X -> 8, diagonal
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1000000, 2'b00, 4'd8, 4'd4);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd8, 4'd4);
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0000000, 2'b00, 4'd8, 4'd5);
        add(1, 0, 1, 4'd2, 0, 4'd0, 7'b0000001, 2'b01, 4'd8, 4'd5);  // done, requests ignored
        add(1, 0, 0, 4'd0, 1, 4'd2, 7'b0000001, 2'b01, 4'd8, 4'd5);
        add(1, 1, 0, 4'd0, 0, 4'd0, 7'b0000001, 2'b01, 4'd8, 4'd5);  // new_game
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b1100000, 2'b01, 4'd8, 4'd5);  // S_CLEAR
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0100000, 2'b00, 4'd8, 4'd0);  // S_CLR_END
        add(1, 0, 0, 4'd0, 0, 4'd0, 7'b0010000, 2'b00, 4'd8, 4'd0);  // S_PLAYER

        reset_n = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset_n      = vecs[i].rst_n;
            new_game     = vecs[i].ng;
            player_valid = vecs[i].pv;
            player_loc   = vecs[i].pl;
            ai_valid     = vecs[i].av;
            ai_loc       = vecs[i].al;
            #1;
            act_v = {submit, board_reset, player_ready, ai_ready, ai_start, reject, game_over,
                     winner, update_loc, move_count};
            exp_v = {vecs[i].flags, vecs[i].win, vecs[i].upd, vecs[i].mc};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL vec[%0d]: got %b want %b (sub,brst,prdy,ardy,ast,rej,go,win,upd,mc)",
                         i, act_v, exp_v);
            end
        end
        player_valid = 1'b0;
        ai_valid     = 1'b0;
        chk("board_cleared_after_new_game", 32'(board), 32'd0);

        // X takes the top row while O holds 3 and 4.
        play_player(4'd0);
        play_ai(4'd3);
        play_player(4'd1);
        play_ai(4'd4);
        play_player(4'd2);
        wait_sig(2, "row_win_game_over");
        chk("row_win_winner", 32'(winner), 32'd1);
        chk("row_win_move_count", 32'(move_count), 32'd5);
        player_valid = 1'b1;
        player_loc   = 4'd5;
        #1;
        chk("done_player_ready", 32'(player_ready), 32'd0);
        chk("done_no_reject", 32'(reject), 32'd0);
        @(negedge clk); #1;
        player_valid = 1'b0;
        chk("done_no_submit", 32'(submit), 32'd0);
        chk("done_still_over", 32'(game_over), 32'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_cell5_blank", 32'(board[11:10]), 32'd0);

        // Full board with no line.
        new_game = 1'b1;
        @(negedge clk); #1;
        new_game = 1'b0;
        play_player(4'd0); play_ai(4'd1); play_player(4'd2); play_ai(4'd4);
        play_player(4'd3); play_ai(4'd5); play_player(4'd7); play_ai(4'd6);
        play_player(4'd8);
        wait_sig(2, "draw_game_over");
        chk("draw_winner", 32'(winner), 32'd3);
        chk("draw_move_count", 32'(move_count), 32'd9);

        // Silent AI: fallback picks the lowest blank cell (2).
        new_game = 1'b1;
        @(negedge clk); #1;
        new_game = 1'b0;
        play_player(4'd0);
        play_ai(4'd1);
        play_player(4'd5);
        wait_sig(1, "timeout_ai_ready");
        n = 0;
        while (ai_ready === 1'b1 && n < 400) begin
            n++;
            @(negedge clk); #1;
        end
        chk("timeout_wait_cycles", 32'(n), 32'd256);
        chk("timeout_submit", 32'(submit), 32'd1);
        chk("timeout_loc", 32'(update_loc), 32'd2);
        wait_sig(0, "timeout_back_to_player");
        chk("timeout_cell2_is_o", 32'(board[5:4]), 32'd2);
        chk("timeout_move_count", 32'(move_count), 32'd4);

        // new_game while the AI is thinking.
        play_player(4'd3);
        wait_sig(1, "abort_ai_ready");
        new_game = 1'b1;
        @(negedge clk); #1;
        new_game = 1'b0;
        chk("abort_clear_submit", 32'(submit), 32'd1);
        chk("abort_clear_brst", 32'(board_reset), 32'd1);
        @(negedge clk); #1;
        chk("abort_clrend_brst", 32'(board_reset), 32'd1);
        chk("abort_clrend_mc", 32'(move_count), 32'd0);
        @(negedge clk); #1;
        chk("abort_player_ready", 32'(player_ready), 32'd1);
        chk("abort_board_clear", 32'(board), 32'd0);

        // new_game during S_COMMIT: submit falls, board reset wins.
        player_valid = 1'b1;
        player_loc   = 4'd7;
        @(negedge clk); #1;
        player_valid = 1'b0;
        new_game     = 1'b1;
        chk("commit_abort_submit_hi", 32'(submit), 32'd1);
        @(negedge clk); #1;
        new_game = 1'b0;
        chk("commit_abort_submit_lo", 32'(submit), 32'd0);
        chk("commit_abort_brst", 32'(board_reset), 32'd1);
        @(negedge clk); #1;
        @(negedge clk); #1;
        chk("commit_abort_player_ready", 32'(player_ready), 32'd1);
        chk("commit_abort_board_clear", 32'(board), 32'd0);
        chk("commit_abort_mc", 32'(move_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
